ahb_lite_mem_subordinate: RTL
=============================

// Module: ahb_lite_mem_subordinate
// PURPOSE
//  Parametrised AHB-Lite memory subordinate; the next-generation replacement for the fixed-width slave.
//  Provides byte-lane writes, configurable wait states and a two-cycle ERROR response.
//  Addresses every beat from HADDR, with no internal burst counters.
//  Sits behind the decoder/mux; one instance per subordinate slot.
// PARAMETERS
//  DATA_WIDTH   32   HWDATA/HRDATA width; power of 2, 32..1024
//  ADDR_WIDTH   32   HADDR width
//  MEM_DEPTH    256  memory depth in DATA_WIDTH words; byte span = MEM_DEPTH*DATA_WIDTH/8
//  WAIT_STATES  0    HREADYOUT-low cycles inserted per OKAY data phase (0..15)
// PORTS
//  HCLK       in   1           clock; all logic on rising edge
//  HRESETn    in   1           reset, synchronous, active-low
//  HSEL       in   1           subordinate select
//  HADDR      in   ADDR_WIDTH  byte address
//  HTRANS     in   2           IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HWRITE     in   1           1=write
//  HSIZE      in   3           transfer size, 2^HSIZE bytes
//  HBURST     in   3           burst type; informational only
//  HWDATA     in   DATA_WIDTH  write data, valid in data phase
//  HREADY     in   1           bus HREADY (mux output)
//  HRDATA     out  DATA_WIDTH  read data
//  HREADYOUT  out  1           this subordinate's ready
//  HRESP      out  2           00=OKAY 01=ERROR
// BEHAVIOUR
//  Reset (HRESETn=0 at posedge):
//  - HREADYOUT=1, HRESP=00, HRDATA=0, state=IDLE.
//  - Any pending data phase is dropped; no memory write.
//  - Memory contents are not cleared.
//  Address phase accepted when HSEL & HREADY & HTRANS[1] at posedge.
//  - Latches HADDR, HSIZE and HWRITE.
//  - IDLE/BUSY or !HSEL: next data phase is OKAY, zero wait.
//  Error check at acceptance. Any of the following makes the beat an ERROR:
//  - HSIZE > log2(DATA_WIDTH/8)
//  - HADDR not aligned to 2^HSIZE
//  - HADDR >= byte span
//  FSM states: IDLE, WAIT, ERR1, ERR2.
//  - IDLE: HREADYOUT=1, HRESP=00.
//    - Accept OKAY beat: go to WAIT when WAIT_STATES>0, else complete next cycle.
//    - Accept ERROR beat: go to ERR1.
//  - WAIT: HREADYOUT=0 for exactly WAIT_STATES cycles (down-counter), then completion cycle with HREADYOUT=1.
//  - ERR1: HREADYOUT=0, HRESP=01, one cycle, then ERR2.
//  - ERR2: HREADYOUT=1, HRESP=01, one cycle.
//    - A new beat accepted in ERR2 is processed normally.
//    - Otherwise return to IDLE.
//  Completion cycle:
//  - Write: on the posedge ending the completion cycle, HWDATA is written into word HADDR/(DATA_WIDTH/8).
//    - Only bytes [a%B, a%B + 2^HSIZE) are written, where B = DATA_WIDTH/8 (little-endian lanes).
//    - Other bytes in the word are preserved.
//  - Read: HRDATA holds the full word at the latched address during the completion cycle (all lanes driven).
//    - Outside completion, HRDATA holds its last value.
//  Latency: read/write data phase = 1 + WAIT_STATES cycles. ERROR is always 2 cycles; memory is never written.
//  Back-to-back:
//  - The next address phase may overlap a completion cycle.
//  - A read following a write to the same word returns the new data (write is committed before the read word is sampled).
//  HREADY=0 while HSEL: address phase is not accepted; the current state is held.
//  HBURST is ignored; WRAP/INCR addressing is the manager's job. Each beat is checked independently.
//  Error during a burst: ERROR is given for that beat only; later beats are evaluated on their own.
// TESTING
//  T1 Reset release: HRESETn low 3 cycles -> HREADYOUT=1, HRESP=00, HRDATA=0.
//  T2 Byte lanes (DATA_WIDTH=32, WAIT_STATES=0):
//     - Write word 0x11223344 @0x04, then byte 0xAA @0x06 (HSIZE=0, data on lane 2).
//     - Read @0x04 -> HRDATA=0x11AA3344 one cycle after address phase.
//  T3 Wait states (WAIT_STATES=2): single read -> HREADYOUT=0,0 then 1 with data; 3-cycle data phase.
//  T4 ERROR cases: unaligned HSIZE=2 @0x02, and read at byte span (0x400 for MEM_DEPTH=256).
//     - Each -> HREADYOUT 0/1 with HRESP=01 both cycles; memory unchanged.
//  T5 INCR4 write 0x10..0x1C, then WRAP4 read starting 0x18 (0x18,0x1C,0x10,0x14):
//     - Data in wrap order, OKAY, no bubbles.
//  T6 Synchronous reset during a WAIT_STATES=3 write data phase:
//     - Target word unchanged; outputs at reset values next cycle.

Source files
------------

// File: rtl/ahb_lite_mem_subordinate.sv
// AHB-Lite memory subordinate: byte-lane writes, fixed wait states per OKAY beat,
// two-cycle ERROR response. Every beat is decoded independently from HADDR.
module ahb_lite_mem_subordinate #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [1:0]            debug_state
);
  localparam int     BYTES = DATA_WIDTH / 8;
  localparam int     OFF_W = $clog2(BYTES);
  localparam int     IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam longint SPAN  = longint'(MEM_DEPTH) * BYTES;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  accept;
  logic                  beat_err;
  logic                  complete;
  logic                  mem_we;
  logic [BYTES-1:0]      byte_en;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic                  unused_inputs;

  assign unused_inputs = ^{HTRANS[0], HBURST};

  // Handshake: an address phase is taken on a rising edge with HSEL & HREADY &
  // HTRANS[1]; its data phase ends on the first edge where HREADYOUT is high.
  always_comb begin
    accept     = HSEL && HREADY && HTRANS[1];
    align_mask = ~({ADDR_WIDTH{1'b1}} << HSIZE);
    beat_err   = (int'(HSIZE) > OFF_W) || (|(HADDR & align_mask)) ||
                 (64'(HADDR) >= 64'(SPAN));
    complete   = (state_q == ST_IDLE) && pend_q;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      write_q <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      write_q <= write_d;
      size_q  <= size_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    write_d = write_q;
    size_d  = size_q;
    off_d   = off_q;
    idx_d   = idx_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 4'd1) state_d = ST_IDLE;
        cnt_d = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE (possibly a completion cycle) and ERR2 can both take a new beat.
        state_d = ST_IDLE;
        pend_d  = 1'b0;
        if (accept) begin
          write_d = HWRITE;
          size_d  = HSIZE;
          off_d   = HADDR[OFF_W-1:0];
          idx_d   = HADDR[OFF_W +: IDX_W];
          if (beat_err) begin
            state_d = ST_ERR1;
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = 4'(WAIT_STATES);
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    HREADYOUT   = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    HRESP       = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    HRDATA      = (complete && !write_q) ? mem_q[idx_q] : rdata_q;
    debug_state = state_q;
  end

  // Reads sample the array combinationally, so a write committed on the edge
  // that starts a read's completion cycle is already visible.
  always_comb begin
    rdata_d = (complete && !write_q) ? mem_q[idx_q] : rdata_q;
    mem_we  = complete && write_q && HRESETn;
    byte_en = '0;
    for (int i = 0; i < BYTES; i++) begin
      byte_en[i] = (i >= int'(off_q)) && (i < int'(off_q) + (1 << size_q));
    end
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (byte_en[i]) mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule
